reg_file: RTL
=============

Name: reg_file

Overview:
- Parametrised multi-port register bank; successor to the single 32-bit load/reset register.
- Holds DEPTH words of WIDTH bits, with one synchronous write port and two asynchronous read ports.
- Supports an optional hardwired-zero entry 0 and optional write-to-read bypass.
- Sits in the CPU datapath as the general-purpose register file between decode and ALU.

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; must be a power of two, >= 2.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a read of the address being written this cycle returns the write data.
- AW, derived = $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- c  input  1  clock; all state updates on rising edge.
- r  input  1  reset, asynchronous, active-low; clears every register while low.
- l  input  1  write (load) enable; sampled on rising edge of c.
- wa  input  AW  write address.
- d  input  WIDTH  write data.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- q1  output  WIDTH  read data, port 1, combinational.
- q2  output  WIDTH  read data, port 2, combinational.
- cnt  output  AW+1  count of registers written since reset; saturates at DEPTH.

Behaviour:
- Reset (r=0, any time, independent of c):
  - all DEPTH entries = 0 and cnt = 0 immediately.
  - q1 and q2 therefore read 0.
  - Writes are blocked while r=0.
- Reset release: the first rising edge of c with r=1 may write.
- Write:
  - On rising edge of c with r=1 and l=1, mem[wa] <= d.
  - Latency: visible on q1/q2 through the array from the next cycle.
  - With l=0, all contents hold.
- Zero register (ZERO_REG=1):
  - A write with wa=0 is discarded; mem[0] stays 0.
  - q1/q2 read 0 for address 0, including under bypass.
  - cnt does not change for such a write.
- Read: q1 = value(ra1) and q2 = value(ra2), purely combinational from address and contents.
- Bypass (BYPASS=1):
  - If l=1, r=1 and raN==wa (and not the zero register), qN = d in the same cycle, before the edge.
  - With BYPASS=0, qN shows the old contents until after the edge.
- Both ports may read the same address; both return identical data.
- Occupancy counter:
  - Per-entry written-flag, cleared on reset.
  - On a write to an entry whose flag is 0, set the flag and cnt <= cnt+1.
  - Rewrites of an already-written entry leave cnt unchanged.
  - cnt maxes at DEPTH (DEPTH-1 when ZERO_REG=1); never wraps.
- Addresses are always in range (power-of-two DEPTH); no out-of-range handling needed.
- Unknown (X) l with r=1 is a user error; no required behaviour.
- Reset mid-cycle while l=1: reset wins, the write is lost, and cnt = 0.

Test Plan:
- Reset: r=0 with random d, l=1, clock toggling -> q1=q2=0 and cnt=0 on all addresses; release r, write wa=5 d=32'h00000001 -> next cycle ra1=5 gives q1=32'h00000001, cnt=1.
- Hold: write wa=3 d=32'h00000111, then l=0 with d=32'hFFFFFFFF for 3 cycles -> ra2=3 still gives 32'h00000111; cnt unchanged.
- Zero register: l=1, wa=0, d=32'hDEADBEEF -> q1 at ra1=0 stays 0 before and after the edge; cnt unchanged.
- Bypass: BYPASS=1, mem[7]=32'h12345678, l=1, wa=7, d=32'hCAFEF00D, ra1=7, ra2=6 -> q1=32'hCAFEF00D before the edge, q2=mem[6]; with BYPASS=0, q1=32'h12345678 until the edge.
- Counter saturation: DEPTH=8, ZERO_REG=1, write addresses 1..7 then 1..7 again -> cnt climbs to 7 and stays 7.
- Async reset mid-operation: during a write cycle, drop r between clock edges -> all qN=0 and cnt=0 without a clock edge; the pending write does not occur.

Source files
------------

// File: rtl/reg_file.sv
// General-purpose register bank: one synchronous write port, two combinational
// read ports, optional hardwired-zero entry 0, optional write-to-read bypass.
module reg_file #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             c,
  input  logic             r,
  input  logic             l,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [AW:0]      cnt
);

  // Entry 0 cannot be written when hardwired to zero, so the ceiling drops by one.
  localparam logic [AW:0] CNT_MAX = (AW+1)'((ZERO_REG != 0) ? (DEPTH - 1) : DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_d;
  logic [DEPTH-1:0]            written_q;
  logic [DEPTH-1:0]            written_d;
  logic [AW:0]                 cnt_q;
  logic [AW:0]                 cnt_d;
  logic                        wr_en_s;
  logic                        byp_en_s;

  function automatic logic is_zero_entry(input logic [AW-1:0] addr);
    logic z;
    if (ZERO_REG != 0) begin
      z = (addr == '0);
    end else begin
      z = 1'b0;
    end
    return z;
  endfunction

  function automatic logic [WIDTH-1:0] read_word(
    input logic [AW-1:0]                 addr,
    input logic [DEPTH-1:0][WIDTH-1:0]   mem,
    input logic                          byp_en,
    input logic [AW-1:0]                 waddr,
    input logic [WIDTH-1:0]              wdata
  );
    logic [WIDTH-1:0] v;
    if (is_zero_entry(addr)) begin
      v = '0;
    end else if ((BYPASS != 0) && byp_en && (addr == waddr)) begin
      v = wdata;
    end else begin
      v = mem[addr];
    end
    return v;
  endfunction

  // Write qualification; bypass is also gated by reset so reads stay 0 while r is low.
  always_comb begin
    wr_en_s  = l & ~is_zero_entry(wa);
    byp_en_s = l & r;
  end

  // Next-state for array, written flags and occupancy counter.
  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    cnt_d     = cnt_q;
    if (wr_en_s) begin
      mem_d[wa] = d;
      if (!written_q[wa]) begin
        written_d[wa] = 1'b1;
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + (AW+1)'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        written_d[wa] = 1'b1;
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // State registers; asynchronous reset clears everything and blocks writes.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      mem_q     <= '0;
      written_q <= '0;
      cnt_q     <= '0;
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
      cnt_q     <= cnt_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    q1  = read_word(ra1, mem_q, byp_en_s, wa, d);
    q2  = read_word(ra2, mem_q, byp_en_s, wa, d);
    cnt = cnt_q;
  end

endmodule
